// File: rtl/alu_cmd_issuer.sv
// Initiator front end for the fixed-point ALU: command FIFO, single-beat issue FSM
// with transpose sequencing, and a response FIFO sized so ALU results never overflow.
module alu_cmd_issuer #(
    parameter int INST_W    = 4,
    parameter int DATA_W    = 16,
    parameter int CMD_DEPTH = 4,
    parameter int RSP_DEPTH = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [INST_W-1:0] i_cmd_inst,
    input  logic [DATA_W-1:0] i_cmd_a,
    input  logic [DATA_W-1:0] i_cmd_b,
    output logic              o_alu_in_valid,
    input  logic              i_alu_busy,
    output logic [INST_W-1:0] o_alu_inst,
    output logic [DATA_W-1:0] o_alu_data_a,
    output logic [DATA_W-1:0] o_alu_data_b,
    input  logic              i_alu_out_valid,
    input  logic [DATA_W-1:0] i_alu_data,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [INST_W-1:0] o_rsp_inst,
    output logic [DATA_W-1:0] o_rsp_data,
    output logic              o_seq_err
);

    localparam int CMD_AW = $clog2(CMD_DEPTH);
    localparam int RSP_AW = $clog2(RSP_DEPTH);
    localparam logic [INST_W-1:0] TP_OP       = INST_W'(4'b1001);
    localparam logic [RSP_AW:0]   RSP_DEPTH_L = {1'b1, {RSP_AW{1'b0}}};

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t      state;
    logic [2:0]  tp_cnt;
    logic [3:0]  rem;

    // ---------------- command FIFO ----------------
    logic [INST_W-1:0] cmd_inst_mem [CMD_DEPTH];
    logic [DATA_W-1:0] cmd_a_mem    [CMD_DEPTH];
    logic [DATA_W-1:0] cmd_b_mem    [CMD_DEPTH];
    logic [CMD_AW:0]   cmd_wr_ptr, cmd_rd_ptr;
    logic              cmd_empty, cmd_full, cmd_push, cmd_pop;
    logic [INST_W-1:0] head_inst;
    logic [DATA_W-1:0] head_a, head_b;

    assign cmd_empty   = (cmd_wr_ptr == cmd_rd_ptr);
    assign cmd_full    = (cmd_wr_ptr[CMD_AW] != cmd_rd_ptr[CMD_AW]) &&
                         (cmd_wr_ptr[CMD_AW-1:0] == cmd_rd_ptr[CMD_AW-1:0]);
    assign o_cmd_ready = !cmd_full;
    assign cmd_push    = i_cmd_valid && o_cmd_ready;
    assign head_inst   = cmd_inst_mem[cmd_rd_ptr[CMD_AW-1:0]];
    assign head_a      = cmd_a_mem[cmd_rd_ptr[CMD_AW-1:0]];
    assign head_b      = cmd_b_mem[cmd_rd_ptr[CMD_AW-1:0]];

    // NOTE: storage arrays carry no reset; emptiness is defined by the pointers alone.
    always_ff @(posedge i_clk) begin
        if (cmd_push) begin
            cmd_inst_mem[cmd_wr_ptr[CMD_AW-1:0]] <= i_cmd_inst;
            cmd_a_mem[cmd_wr_ptr[CMD_AW-1:0]]    <= i_cmd_a;
            cmd_b_mem[cmd_wr_ptr[CMD_AW-1:0]]    <= i_cmd_b;
        end
    end

    // ---------------- response FIFO ----------------
    logic [INST_W-1:0] rsp_inst_mem [RSP_DEPTH];
    logic [DATA_W-1:0] rsp_data_mem [RSP_DEPTH];
    logic [RSP_AW:0]   rsp_wr_ptr, rsp_rd_ptr, rsp_count, rsp_free;
    logic              rsp_empty, rsp_full, rsp_push, rsp_pop;

    assign rsp_empty   = (rsp_wr_ptr == rsp_rd_ptr);
    assign rsp_full    = (rsp_wr_ptr[RSP_AW] != rsp_rd_ptr[RSP_AW]) &&
                         (rsp_wr_ptr[RSP_AW-1:0] == rsp_rd_ptr[RSP_AW-1:0]);
    assign rsp_count   = rsp_wr_ptr - rsp_rd_ptr;
    assign rsp_free    = RSP_DEPTH_L - rsp_count;
    assign o_rsp_valid = !rsp_empty;
    assign rsp_pop     = o_rsp_valid && i_rsp_ready;
    // A full FIFO still accepts a result when the head leaves in the same cycle.
    assign rsp_push    = i_alu_out_valid && (!rsp_full || rsp_pop);
    assign o_rsp_inst  = rsp_inst_mem[rsp_rd_ptr[RSP_AW-1:0]];
    assign o_rsp_data  = rsp_data_mem[rsp_rd_ptr[RSP_AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (rsp_push) begin
            rsp_inst_mem[rsp_wr_ptr[RSP_AW-1:0]] <= o_alu_inst;
            rsp_data_mem[rsp_wr_ptr[RSP_AW-1:0]] <= i_alu_data;
        end
    end

    // ---------------- issue decision ----------------
    logic       head_tp, do_issue, final_issue, seq_drop;
    logic [3:0] need;

    assign head_tp = (head_inst == TP_OP);
    assign need    = head_tp ? 4'd8 : 4'd1;

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        cmd_pop     = 1'b0;
        do_issue    = 1'b0;
        final_issue = 1'b0;
        seq_drop    = 1'b0;
        if (state == S_IDLE && !cmd_empty && !i_alu_busy) begin
            if (!head_tp && tp_cnt != 3'd0) begin
                cmd_pop  = 1'b1;
                seq_drop = 1'b1;
            end else if (head_tp && tp_cnt != 3'd7) begin
                cmd_pop  = 1'b1;
                do_issue = 1'b1;
            end else if (rsp_free >= (RSP_AW+1)'(need)) begin
                // Final beat goes only once every result it triggers has a slot.
                cmd_pop     = 1'b1;
                do_issue    = 1'b1;
                final_issue = 1'b1;
            end
        end
    end

    // ---------------- sequential state ----------------
    // NOTE: state registers use non-blocking assignments so every read sees the pre-edge value.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state          <= S_IDLE;
            tp_cnt         <= 3'd0;
            rem            <= 4'd0;
            cmd_wr_ptr     <= '0;
            cmd_rd_ptr     <= '0;
            rsp_wr_ptr     <= '0;
            rsp_rd_ptr     <= '0;
            o_alu_in_valid <= 1'b0;
            o_alu_inst     <= '0;
            o_alu_data_a   <= '0;
            o_alu_data_b   <= '0;
            o_seq_err      <= 1'b0;
        end else begin
            o_alu_in_valid <= do_issue;
            o_seq_err      <= seq_drop;
            if (do_issue) begin
                o_alu_inst   <= head_inst;
                o_alu_data_a <= head_a;
                o_alu_data_b <= head_b;
            end
            if (cmd_push) cmd_wr_ptr <= cmd_wr_ptr + 1'b1;
            if (cmd_pop)  cmd_rd_ptr <= cmd_rd_ptr + 1'b1;
            if (rsp_push) rsp_wr_ptr <= rsp_wr_ptr + 1'b1;
            if (rsp_pop)  rsp_rd_ptr <= rsp_rd_ptr + 1'b1;

            case (state)
                S_IDLE: begin
                    if (final_issue) begin
                        tp_cnt <= 3'd0;
                        rem    <= need;
                        state  <= S_WAIT;
                    end else if (do_issue) begin
                        tp_cnt <= tp_cnt + 3'd1;
                    end
                end
                S_WAIT: begin
                    if (i_alu_out_valid) begin
                        rem <= rem - 4'd1;
                        if (rem == 4'd1) state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer with a small behavioural ALU answering each
// issued operation; expected responses are hand-computed per vector.
module tb_alu_cmd_issuer;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_TP  = 4'b1001;
    localparam int ST_IDLE = 0;
    localparam int ST_WAIT = 1;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_cmd_valid = 1'b0;
    logic        o_cmd_ready;
    logic [3:0]  i_cmd_inst = '0;
    logic [15:0] i_cmd_a = '0;
    logic [15:0] i_cmd_b = '0;
    logic        o_alu_in_valid;
    logic        i_alu_busy = 1'b0;
    logic [3:0]  o_alu_inst;
    logic [15:0] o_alu_data_a;
    logic [15:0] o_alu_data_b;
    logic        i_alu_out_valid = 1'b0;
    logic [15:0] i_alu_data = '0;
    logic        o_rsp_valid;
    logic        i_rsp_ready = 1'b0;
    logic [3:0]  o_rsp_inst;
    logic [15:0] o_rsp_data;
    logic        o_seq_err;

    always #5 i_clk = ~i_clk;

    alu_cmd_issuer dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_cmd_valid     (i_cmd_valid),
        .o_cmd_ready     (o_cmd_ready),
        .i_cmd_inst      (i_cmd_inst),
        .i_cmd_a         (i_cmd_a),
        .i_cmd_b         (i_cmd_b),
        .o_alu_in_valid  (o_alu_in_valid),
        .i_alu_busy      (i_alu_busy),
        .o_alu_inst      (o_alu_inst),
        .o_alu_data_a    (o_alu_data_a),
        .o_alu_data_b    (o_alu_data_b),
        .i_alu_out_valid (i_alu_out_valid),
        .i_alu_data      (i_alu_data),
        .o_rsp_valid     (o_rsp_valid),
        .i_rsp_ready     (i_rsp_ready),
        .o_rsp_inst      (o_rsp_inst),
        .o_rsp_data      (o_rsp_data),
        .o_seq_err       (o_seq_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Monitor: beat/seq_err counters sampled just after each rising edge.
    int         cyc = 0;
    int         beats = 0;
    int         seq_errs = 0;
    int         beat_cyc[$];
    logic [3:0] last_inst = '0;

    always @(posedge i_clk) begin
        #1;
        cyc++;
        if (o_alu_in_valid) begin
            beats++;
            beat_cyc.push_back(cyc);
            last_inst = o_alu_inst;
        end
        if (o_seq_err) seq_errs++;
    end

    // Behavioural ALU: results two cycles after the operation, transpose returns
    // its eight A operands after the final beat; busy while results are pending.
    function automatic logic [15:0] alu_fn(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            default: return a ^ b;
        endcase
    endfunction

    logic [15:0] tp_buf[$];
    logic [15:0] res_q[$];
    int          countdown = 0;
    logic        rst_seen = 1'b0;

    always @(posedge i_clk) rst_seen <= i_rst;

    always @(negedge i_clk) begin
        if (rst_seen) begin
            tp_buf.delete();
            res_q.delete();
            countdown = 0;
            i_alu_out_valid = 1'b0;
            i_alu_busy = 1'b0;
        end else begin
            if (o_alu_in_valid) begin
                if (o_alu_inst == OP_TP) begin
                    tp_buf.push_back(o_alu_data_a);
                    if (tp_buf.size() == 8) begin
                        res_q = tp_buf;
                        tp_buf.delete();
                        countdown = 2;
                    end
                end else begin
                    res_q.push_back(alu_fn(o_alu_inst, o_alu_data_a, o_alu_data_b));
                    countdown = 2;
                end
            end
            if (countdown > 0) begin
                countdown--;
                i_alu_out_valid = 1'b0;
            end else if (res_q.size() > 0) begin
                i_alu_out_valid = 1'b1;
                i_alu_data = res_q.pop_front();
            end else begin
                i_alu_out_valid = 1'b0;
            end
            i_alu_busy = (res_q.size() != 0) || (countdown != 0);
        end
    end

    // All stimulus tasks are entered and left on a falling edge.
    task automatic send_cmd(input logic [3:0] inst, input logic [15:0] a, input logic [15:0] b);
        int n = 0;
        i_cmd_valid = 1'b1;
        i_cmd_inst  = inst;
        i_cmd_a     = a;
        i_cmd_b     = b;
        while (!o_cmd_ready && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        if (!o_cmd_ready) check("cmd_ready_timeout", 32'(o_cmd_ready), 32'd1);
        @(negedge i_clk);
        i_cmd_valid = 1'b0;
    endtask

    task automatic pop_rsp(input string tag, input logic [3:0] inst, input logic [15:0] data);
        int n = 0;
        while (!o_rsp_valid && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        check({tag, "_valid"}, 32'(o_rsp_valid), 32'd1);
        check({tag, "_inst"},  32'(o_rsp_inst),  32'(inst));
        check({tag, "_data"},  32'(o_rsp_data),  32'(data));
        i_rsp_ready = 1'b1;
        @(negedge i_clk);
        i_rsp_ready = 1'b0;
    endtask

    task automatic wait_beats(input string tag, input int n);
        int k = 0;
        while (beats < n && k < 200) begin
            @(negedge i_clk);
            k++;
        end
        check({tag, "_beat_wait"}, 32'(beats), 32'(n));
    endtask

    int b0;
    int s0;

    initial begin
        // Reset state
        repeat (3) @(negedge i_clk);
        check("rst_cmd_ready", 32'(o_cmd_ready),    32'd1);
        check("rst_in_valid",  32'(o_alu_in_valid), 32'd0);
        check("rst_rsp_valid", 32'(o_rsp_valid),    32'd0);
        check("rst_seq_err",   32'(o_seq_err),      32'd0);
        check("rst_alu_inst",  32'(o_alu_inst),     32'd0);
        check("rst_alu_a",     32'(o_alu_data_a),   32'd0);
        check("rst_alu_b",     32'(o_alu_data_b),   32'd0);
        check("rst_tp_cnt",    32'(dut.tp_cnt),     32'd0);
        i_rst = 1'b0;

        // Single add: 0x0400 + 0x0C00 = 0x1000, beat two cycles after acceptance
        b0 = beats;
        send_cmd(OP_ADD, 16'h0400, 16'h0C00);
        check("add_decide_cycle", 32'(o_alu_in_valid), 32'd0);
        @(negedge i_clk);
        check("add_beat_valid", 32'(o_alu_in_valid), 32'd1);
        check("add_beat_inst",  32'(o_alu_inst),     32'(OP_ADD));
        check("add_beat_a",     32'(o_alu_data_a),   32'h0400);
        check("add_beat_b",     32'(o_alu_data_b),   32'h0C00);
        @(negedge i_clk);
        check("add_beat_drop", 32'(o_alu_in_valid), 32'd0);
        pop_rsp("add_rsp", OP_ADD, 16'h1000);
        check("add_state_idle", 32'(dut.state), 32'(ST_IDLE));
        check("add_beat_count", 32'(beats - b0), 32'd1);

        // Transpose: 8 consecutive beats, then a SUB held until the ALU is free
        b0 = beats;
        for (int k = 0; k < 8; k++) send_cmd(OP_TP, 16'h0100 + 16'(k), 16'h0000);
        wait_beats("tp", b0 + 8);
        check("tp_state_wait", 32'(dut.state), 32'(ST_WAIT));
        check("tp_cnt_clear",  32'(dut.tp_cnt), 32'd0);
        check("tp_back_to_back", 32'(beat_cyc[beat_cyc.size()-1] - beat_cyc[beat_cyc.size()-8]), 32'd7);
        send_cmd(OP_SUB, 16'h0005, 16'h0003);
        check("tp_sub_held", 32'(beats - b0), 32'd8);
        for (int k = 0; k < 8; k++) pop_rsp($sformatf("tp_rsp%0d", k), OP_TP, 16'h0100 + 16'(k));
        wait_beats("tp_sub", b0 + 9);
        check("tp_sub_inst", 32'(last_inst), 32'(OP_SUB));
        pop_rsp("sub_rsp", OP_SUB, 16'h0002);

        // Response backpressure: 8 stored results block the 9th add
        b0 = beats;
        for (int k = 1; k <= 9; k++) send_cmd(OP_ADD, 16'(k), 16'h0100);
        wait_beats("bp", b0 + 8);
        repeat (20) @(negedge i_clk);
        check("bp_ninth_held", 32'(beats - b0), 32'd8);
        pop_rsp("bp_rsp1", OP_ADD, 16'h0101);
        wait_beats("bp_ninth", b0 + 9);
        for (int k = 2; k <= 9; k++) pop_rsp($sformatf("bp_rsp%0d", k), OP_ADD, 16'h0100 + 16'(k));

        // Transpose reservation: one stored response holds the final beat
        b0 = beats;
        send_cmd(OP_ADD, 16'h0001, 16'h0001);
        wait_beats("res_add", b0 + 1);
        repeat (6) @(negedge i_clk);
        check("res_one_stored", 32'(o_rsp_valid), 32'd1);
        for (int k = 0; k < 8; k++) send_cmd(OP_TP, 16'h0200 + 16'(k), 16'h0000);
        repeat (10) @(negedge i_clk);
        check("res_final_held", 32'(beats - b0), 32'd8);
        check("res_tp_cnt7",    32'(dut.tp_cnt), 32'd7);
        pop_rsp("res_add_rsp", OP_ADD, 16'h0002);
        wait_beats("res_final", b0 + 9);
        for (int k = 0; k < 8; k++) pop_rsp($sformatf("res_rsp%0d", k), OP_TP, 16'h0200 + 16'(k));

        // Sequence error: SUB inside a transpose is dropped with a single pulse
        b0 = beats;
        s0 = seq_errs;
        for (int k = 0; k < 3; k++) send_cmd(OP_TP, 16'h0300 + 16'(k), 16'h0000);
        send_cmd(OP_SUB, 16'h0007, 16'h0007);
        repeat (4) @(negedge i_clk);
        check("seq_err_pulse", 32'(seq_errs - s0), 32'd1);
        check("seq_tp_cnt",    32'(dut.tp_cnt),    32'd3);
        check("seq_no_beat",   32'(beats - b0),    32'd3);
        for (int k = 3; k < 8; k++) send_cmd(OP_TP, 16'h0300 + 16'(k), 16'h0000);
        wait_beats("seq_tp", b0 + 8);
        for (int k = 0; k < 8; k++) pop_rsp($sformatf("seq_rsp%0d", k), OP_TP, 16'h0300 + 16'(k));
        check("seq_err_total", 32'(seq_errs - s0), 32'd1);

        // Mid-wait reset abandons the operation
        b0 = beats;
        send_cmd(OP_ADD, 16'h0A00, 16'h0200);
        wait_beats("mwr", b0 + 1);
        @(negedge i_clk);
        check("mwr_state_wait", 32'(dut.state), 32'(ST_WAIT));
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        check("mwr_rsp_valid", 32'(o_rsp_valid),    32'd0);
        check("mwr_cmd_ready", 32'(o_cmd_ready),    32'd1);
        check("mwr_state",     32'(dut.state),      32'(ST_IDLE));
        check("mwr_in_valid",  32'(o_alu_in_valid), 32'd0);
        repeat (4) @(negedge i_clk);
        check("mwr_no_stale_rsp", 32'(o_rsp_valid), 32'd0);
        send_cmd(OP_ADD, 16'h0A00, 16'h0200);
        pop_rsp("mwr_add_rsp", OP_ADD, 16'h0C00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got %0d errors of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_cmd_issuer.md
Name: alu_cmd_issuer

Overview:
- Initiator-side front end for the fixed-point ALU.
- Buffers upstream commands in a command FIFO and drives the ALU's `valid`/`busy` input handshake one beat per command.
- Captures every ALU output beat into a response FIFO tagged with its opcode, and presents that FIFO downstream with `valid`/`ready`.
- Serialises operations and reserves response space before issue, so the ALU's non-stallable output never overflows.

Parameters:
- INST_W, 4, opcode width
- DATA_W, 16, operand/result width (Q6.10)
- CMD_DEPTH, 4, command FIFO entries (power of 2, ≥2)
- RSP_DEPTH, 8, response FIFO entries (power of 2, ≥8)

Ports:
- i_clk  in  1  clock; all logic on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_cmd_valid  in  1  upstream command valid
- o_cmd_ready  out  1  command FIFO not full
- i_cmd_inst  in  INST_W  opcode
- i_cmd_a  in  DATA_W  operand A (transpose: row data)
- i_cmd_b  in  DATA_W  operand B
- o_alu_in_valid  out  1  one-cycle beat to ALU, registered
- i_alu_busy  in  1  ALU busy
- o_alu_inst  out  INST_W  opcode to ALU, registered
- o_alu_data_a  out  DATA_W  operand A to ALU, registered
- o_alu_data_b  out  DATA_W  operand B to ALU, registered
- i_alu_out_valid  in  1  ALU result beat
- i_alu_data  in  DATA_W  ALU result
- o_rsp_valid  out  1  response FIFO not empty
- i_rsp_ready  in  1  downstream accepts
- o_rsp_inst  out  INST_W  opcode of head response
- o_rsp_data  out  DATA_W  head response data
- o_seq_err  out  1  one-cycle pulse: command dropped

Behaviour:
- Reset (i_rst=1 at an edge):
  - Both FIFOs are emptied and the FSM goes to S_IDLE.
  - o_cmd_ready=1; o_alu_in_valid, o_rsp_valid and o_seq_err are 0.
  - o_alu_inst, o_alu_data_a, o_alu_data_b are 0; tp_cnt=0.
  - Reset mid-operation abandons the operation; the ALU is reset in the same cycle by the system.
- Command FIFO:
  - Push when i_cmd_valid & o_cmd_ready.
  - o_cmd_ready = !full. Ready does not account for a same-cycle pop.
- Opcode 4'b1001 (transpose) takes 8 beats. Every other opcode takes 1 beat.
- tp_cnt (3 bits) counts transpose beats already issued.
- Final beat:
  - Non-transpose command: its only beat.
  - Transpose: the beat issued with tp_cnt==7.
  - need = 8 result beats for transpose, 1 otherwise.
- FSM:
  - S_IDLE: pop the head command when the FIFO is not empty and i_alu_busy==0.
    - Non-final transpose beat (tp_cnt<7): issue, tp_cnt++, stay in S_IDLE. Back-to-back beats on consecutive cycles are legal.
    - Final beat: issue only if the response FIFO has ≥ need free entries; otherwise hold without popping. Then set tp_cnt=0, rem=need, go to S_WAIT.
    - Non-transpose head while tp_cnt≠0: pop and discard, no ALU beat, o_seq_err=1 the next cycle. tp_cnt is unchanged.
  - S_WAIT: no issue. Each i_alu_out_valid decrements rem. At rem 1→0, go to S_IDLE.
- Issue timing:
  - Decision in cycle t.
  - o_alu_in_valid=1 with registered operands during t+1 only, then 0.
- Response FIFO:
  - Push {o_alu_inst of the last issued beat, i_alu_data} on every i_alu_out_valid.
  - Pop on o_rsp_valid & i_rsp_ready. Show-ahead head.
  - Simultaneous push and pop are allowed at any occupancy.
  - Overflow cannot occur because of the issue reservation.
  - i_alu_out_valid while in S_IDLE is pushed anyway if space exists, otherwise dropped.
- Latency:
  - Command accepted into an empty FIFO with the ALU idle → o_alu_in_valid 2 cycles later.
  - Response is visible on o_rsp_valid 1 cycle after i_alu_out_valid.
- Pointer wrap uses an extra MSB for full/empty. The counters are sized by the depth parameters.

Test Plan:
- Single add: cmd {0000, 0x0400, 0x0C00}, ALU model returns 0x1000 → one beat on o_alu_in_valid; response {0000, 0x1000}; FSM back to S_IDLE.
- Transpose: 8 cmds opcode 1001 on consecutive cycles → 8 consecutive ALU beats with tp_cnt 0..7 and S_WAIT after the 8th; 8 ALU results all tagged 1001 and delivered in order; the next cmd issues only after i_alu_busy falls.
- Response backpressure: i_rsp_ready=0, 8 single-beat adds → 8 responses stored; a 9th add is held in the cmd FIFO with no ALU beat; one pop → 9th issues.
- Transpose reservation: response FIFO holding 1 entry, transpose final beat pending → final beat held until occupancy reaches 0.
- Sequence error: 3 transpose beats then a 0001 cmd → 0001 dropped, o_seq_err pulses once, tp_cnt stays 3; 5 more 1001 beats complete the transpose normally.
- Mid-wait reset: i_rst for 1 cycle while in S_WAIT → o_rsp_valid=0, o_cmd_ready=1, FSM in S_IDLE, a following add completes normally.
